// File: rtl/i2c_slave_responder.sv
// I2C slave responder: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte writes out via DOUT/WE_OUT and byte reads fetched through RD_REQ/DIN.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h21
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       I2C_SCL,
    input  logic       I2C_SDA_IN,
    output logic       I2C_SDA_OE,
    output logic [7:0] DOUT,
    output logic       WE_OUT,
    input  logic [7:0] DIN,
    output logic       RD_REQ,
    output logic       BUSY,
    output logic       ADDR_HIT
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q;
    logic       scl_rise_d, scl_fall_d, start_d, stop_d;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       pend_q, pend_d;
    logic       oe_q, oe_d;
    logic [7:0] dout_q, dout_d;
    logic       we_q, we_d;
    logic       rd_req_q, rd_req_d;
    logic       busy_q, busy_d;
    logic       hit_q, hit_d;
    logic       sda_bit;

    assign sda_bit = sda_sync_q[2];

    // Strobes are registered so each bus event is seen as a single one-CLK pulse
    always_comb begin
        scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
        start_d    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
        stop_d     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        rw_d     = rw_q;
        pend_d   = pend_q;
        oe_d     = oe_q;
        dout_d   = dout_q;
        we_d     = 1'b0;
        rd_req_d = 1'b0;
        busy_d   = busy_q;
        hit_d    = hit_q;

        if (stop_q) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            hit_d   = 1'b0;
            cnt_d   = 3'd0;
            pend_d  = 1'b0;
        end else if (start_q) begin
            state_d = ADDR;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
            hit_d   = 1'b0;
            cnt_d   = 3'd0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                // ADDR_HIT doubles as the "address byte complete" flag for the ACK fall
                ADDR: begin
                    if (scl_rise_q) begin
                        shift_d = {shift_q[5:0], sda_bit};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shift_q == SLAVE_ADDR && shift_q != 7'h00) begin
                                hit_d = 1'b1;
                                rw_d  = sda_bit;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall_q && hit_q) begin
                        oe_d    = 1'b1;
                        state_d = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (rw_q) begin
                        if (scl_rise_q) begin
                            rd_req_d = 1'b1;
                        end else if (scl_fall_q) begin
                            tx_d    = DIN[6:0];
                            oe_d    = ~DIN[7];
                            cnt_d   = 3'd0;
                            state_d = RD_BYTE;
                        end
                    end else if (scl_fall_q) begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    if (scl_rise_q) begin
                        shift_d = {shift_q[5:0], sda_bit};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            dout_d = {shift_q, sda_bit};
                            we_d   = 1'b1;
                            pend_d = 1'b1;
                        end
                    end else if (scl_fall_q && pend_q) begin
                        oe_d    = 1'b1;
                        pend_d  = 1'b0;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_q) begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = WR_BYTE;
                    end
                end
                // Bit 7 went out on entry; falls 1..7 present bits 6..0, the 8th releases SDA
                RD_BYTE: begin
                    if (scl_fall_q) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = RD_ACK;
                        end else begin
                            tx_d  = {tx_q[5:0], 1'b0};
                            oe_d  = ~tx_q[6];
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise_q) begin
                        if (!sda_bit) begin
                            rd_req_d = 1'b1;
                            pend_d   = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall_q && pend_q) begin
                        tx_d    = DIN[6:0];
                        oe_d    = ~DIN[7];
                        pend_d  = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = RD_BYTE;
                    end
                end
                IGNORE: oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    // Sync chains reset to the idle-bus level so release of reset creates no false edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 7'd0;
            tx_q       <= 7'd0;
            rw_q       <= 1'b0;
            pend_q     <= 1'b0;
            oe_q       <= 1'b0;
            dout_q     <= 8'h00;
            we_q       <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], I2C_SCL};
            sda_sync_q <= {sda_sync_q[1:0], I2C_SDA_IN};
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            pend_q     <= pend_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
        end
    end

    assign I2C_SDA_OE = oe_q;
    assign DOUT       = dout_q;
    assign WE_OUT     = we_q;
    assign RD_REQ     = rd_req_q;
    assign BUSY       = busy_q;
    assign ADDR_HIT   = hit_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bus-level I2C master model, monitors and
// transaction-level expectations (addressed?, bytes written, bytes read).
module tb_i2c_slave_responder;

    localparam logic [6:0] SLV = 7'h21;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] din = 8'h00;
    logic       oe, we, rd_req, busy, hit;
    logic [7:0] dout;
    logic       sda_bus;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] we_log[$];
    logic [7:0] din_q[$];
    int         oe_runs[$];
    int         rd_pulses = 0, oe_seen = 0, hit_seen = 0, oe_run = 0;
    int         overlap = 0, wide = 0;
    logic       we_prev = 1'b0, rd_prev = 1'b0;

    assign sda_bus = sda_m & ~oe;

    always #5 clk = ~clk;

    i2c_slave_responder #(.SLAVE_ADDR(SLV)) dut (
        .CLK(clk), .RST(rst), .I2C_SCL(scl_m), .I2C_SDA_IN(sda_bus),
        .I2C_SDA_OE(oe), .DOUT(dout), .WE_OUT(we), .DIN(din),
        .RD_REQ(rd_req), .BUSY(busy), .ADDR_HIT(hit)
    );

    // Monitor: log written bytes, serve DIN on each request, measure OE runs
    always @(negedge clk) begin
        if (we) we_log.push_back(dout);
        if (rd_req) begin
            rd_pulses++;
            if (din_q.size() > 0) din = din_q.pop_front();
            else din = 8'($urandom);
        end
        if (we && rd_req) overlap++;
        if ((we && we_prev) || (rd_req && rd_prev)) wide++;
        we_prev = we;
        rd_prev = rd_req;
        if (oe) begin
            oe_seen++;
            oe_run++;
        end else if (oe_run > 0) begin
            oe_runs.push_back(oe_run);
            oe_run = 0;
        end
        if (hit) hit_seen = 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        we_log.delete();
        din_q.delete();
        oe_runs.delete();
        rd_pulses = 0;
        oe_seen = 0;
        hit_seen = 0;
        oe_run = 0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(5); sda_m = 1'b1; wait_clk(5); scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b0; wait_clk(10); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(5); sda_m = 1'b0; wait_clk(5); scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b1; wait_clk(10);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        wait_clk(5); sda_m = b; wait_clk(5); scl_m = 1'b1;
        wait_clk(5); s = sda_bus; wait_clk(5); scl_m = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic bus_read(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    task automatic test_reset();
        logic [12:0] got;
        got = {oe, dout, we, rd_req, busy, hit};
        tests_run++;
        if (got !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", got);
        end
        rst = 1'b0;
        wait_clk(5);
        tests_run++;
        if ({oe, busy, hit} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: oe/busy/hit got %b expected 000", {oe, busy, hit});
        end
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        clear_mon();
        bus_start();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
        bus_write({SLV, 1'b0}, a0);
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_hit: got %b expected 1", hit); end
        bus_write(8'hA5, a1);
        bus_write(8'h3C, a2);
        bus_stop();
        tests_run++;
        if ({a0, a1, a2} !== 3'b111) begin tests_failed++; $display("[TB] FAIL write_acks: got %b expected 111", {a0, a1, a2}); end
        tests_run++;
        if (we_log.size() != 2 || we_log[0] !== 8'hA5 || we_log[1] !== 8'h3C) begin
            tests_failed++;
            $display("[TB] FAIL write_data: got %0d bytes %p expected A5 3C", we_log.size(), we_log);
        end
        tests_run++;
        if (busy !== 1'b0 || hit !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_after_stop: busy/hit got %b%b expected 00", busy, hit);
        end
        tests_run++;
        if (oe_runs.size() != 3 || oe_runs[0] != 20 || oe_runs[1] != 20 || oe_runs[2] != 20) begin
            tests_failed++;
            $display("[TB] FAIL write_ack_width: got runs %p expected three of 20 CLK", oe_runs);
        end
    endtask

    task automatic test_read();
        logic a0;
        logic [7:0] d0, d1;
        clear_mon();
        din_q.push_back(8'h96);
        din_q.push_back(8'h0F);
        bus_start();
        bus_write({SLV, 1'b1}, a0);
        tests_run++;
        if (a0 !== 1'b1 || hit !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL read_addr: ack/hit got %b%b expected 11", a0, hit);
        end
        bus_read(1'b0, d0);
        bus_read(1'b1, d1);
        wait_clk(15);
        tests_run++;
        if (rd_pulses != 2) begin tests_failed++; $display("[TB] FAIL read_req_count: got %0d expected 2", rd_pulses); end
        bus_stop();
        tests_run++;
        if (d0 !== 8'h96 || d1 !== 8'h0F) begin
            tests_failed++;
            $display("[TB] FAIL read_data: got %h %h expected 96 0F", d0, d1);
        end
        tests_run++;
        if (busy !== 1'b0 || oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_after_stop: busy/oe got %b%b expected 00", busy, oe);
        end
    endtask

    task automatic test_wrong_addr();
        logic [7:0] addrs[2];
        logic a0, a1;
        addrs[0] = 8'h50;
        addrs[1] = 8'h00;
        foreach (addrs[k]) begin
            clear_mon();
            bus_start();
            bus_write(addrs[k], a0);
            bus_write(8'($urandom), a1);
            bus_stop();
            tests_run++;
            if ({a0, a1} !== 2'b00 || oe_seen != 0) begin
                tests_failed++;
                $display("[TB] FAIL wrong_addr_%h_oe: acks %b oe cycles %0d expected none", addrs[k], {a0, a1}, oe_seen);
            end
            tests_run++;
            if (we_log.size() != 0 || rd_pulses != 0 || hit_seen != 0) begin
                tests_failed++;
                $display("[TB] FAIL wrong_addr_%h_strobes: we %0d rd %0d hit %0d expected 0 0 0",
                         addrs[k], we_log.size(), rd_pulses, hit_seen);
            end
        end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2;
        logic [7:0] exp_rd, d0;
        clear_mon();
        exp_rd = 8'($urandom);
        din_q.push_back(exp_rd);
        bus_start();
        bus_write({SLV, 1'b0}, a0);
        bus_write(8'h11, a1);
        bus_rstart();
        tests_run++;
        if (hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstart_hit_clear: got %b expected 0", hit); end
        bus_write({SLV, 1'b1}, a2);
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstart_hit_again: got %b expected 1", hit); end
        bus_read(1'b1, d0);
        bus_stop();
        tests_run++;
        if ({a0, a1, a2} !== 3'b111 || d0 !== exp_rd) begin
            tests_failed++;
            $display("[TB] FAIL rstart_xfer: acks %b data %h expected 111 %h", {a0, a1, a2}, d0, exp_rd);
        end
        tests_run++;
        if (we_log.size() != 1 || we_log[0] !== 8'h11 || rd_pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL rstart_strobes: we %p rd %0d expected 11 and 1", we_log, rd_pulses);
        end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, s;
        logic [7:0] b;
        clear_mon();
        bus_start();
        bus_write({SLV, 1'b0}, a0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
        bus_stop();
        tests_run++;
        if (we_log.size() != 0 || busy !== 1'b0 || oe !== 1'b0 || hit !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stop_mid_byte: we %0d busy %b oe %b hit %b expected 0 0 0 0",
                     we_log.size(), busy, oe, hit);
        end
        b = 8'($urandom);
        bus_start();
        bus_write({SLV, 1'b0}, a0);
        bus_write(b, a1);
        bus_stop();
        tests_run++;
        if ({a0, a1} !== 2'b11 || we_log.size() != 1 || we_log[0] !== b) begin
            tests_failed++;
            $display("[TB] FAIL stop_mid_byte_next: acks %b we %p expected 11 and %h", {a0, a1}, we_log, b);
        end
    endtask

    task automatic test_reset_mid_read();
        logic s, a0, a1;
        logic [7:0] addr_rd, b;
        int waited;
        clear_mon();
        addr_rd = {SLV, 1'b1};
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(addr_rd[i], s);
        waited = 0;
        while (oe !== 1'b1 && waited < 30) begin
            wait_clk(1);
            waited++;
        end
        tests_run++;
        if (oe !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_read_wait: oe got %b expected 1 within 30 CLK", oe);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({oe, dout, we, rd_req, busy, hit} !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_read_outputs: got %h expected 0", {oe, dout, we, rd_req, busy, hit});
        end
        wait_clk(3);
        rst = 1'b0;
        sda_m = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        clear_mon();
        b = 8'($urandom);
        bus_start();
        bus_write({SLV, 1'b0}, a0);
        bus_write(b, a1);
        bus_stop();
        tests_run++;
        if ({a0, a1} !== 2'b11 || we_log.size() != 1 || we_log[0] !== b) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_read_next: acks %b we %p expected 11 and %h", {a0, a1}, we_log, b);
        end
    endtask

    task automatic test_random();
        logic [6:0] a7;
        logic       rw, ack, exp_hit;
        int         n, bad;
        logic [7:0] exp_bytes[$];
        logic [7:0] d;
        for (int it = 0; it < 6; it++) begin
            clear_mon();
            exp_bytes.delete();
            a7 = ($urandom_range(0, 1) == 0) ? SLV : 7'($urandom);
            rw = 1'($urandom);
            n = $urandom_range(1, 3);
            exp_hit = (a7 == SLV) && (a7 != 7'h00);
            for (int k = 0; k < n; k++) exp_bytes.push_back(8'($urandom));
            if (rw) foreach (exp_bytes[k]) din_q.push_back(exp_bytes[k]);
            bad = 0;
            bus_start();
            bus_write({a7, rw}, ack);
            tests_run++;
            if (ack !== exp_hit) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_addr_ack: addr %h got %b expected %b", it, a7, ack, exp_hit);
            end
            if (exp_hit) begin
                for (int k = 0; k < n; k++) begin
                    if (rw) begin
                        bus_read(k == n - 1, d);
                        if (d !== exp_bytes[k]) bad++;
                    end else begin
                        bus_write(exp_bytes[k], ack);
                        if (ack !== 1'b1) bad++;
                    end
                end
            end
            bus_stop();
            if (!rw && exp_hit) begin
                if (we_log.size() != n) bad++;
                else foreach (exp_bytes[k]) if (we_log[k] !== exp_bytes[k]) bad++;
            end else if (we_log.size() != 0) bad++;
            if (rd_pulses != ((rw && exp_hit) ? n : 0)) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_xfer: addr %h rw %b n %0d errors %0d we %p rd %0d expected 0 errors",
                         it, a7, rw, n, bad, we_log, rd_pulses);
            end
        end
    endtask

    task automatic test_strobe_hygiene();
        tests_run++;
        if (overlap != 0 || wide != 0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_hygiene: overlap %0d wide %0d expected 0 0", overlap, wide);
        end
    endtask

    initial begin
        wait_clk(5);
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_repeated_start();
        test_stop_mid_byte();
        test_reset_mid_read();
        test_random();
        test_strobe_hygiene();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
